// File: rtl/ir_pkg.sv
// Shared definitions for the IR packet scheduler: FSM state encoding,
// register offsets, control-register bit positions and COMMAND bit layout.
package ir_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIRE = 2'd2
    } ir_state_e;

    // Register offsets from BASE_ADDR
    localparam logic [7:0] CMD_OFS  = 8'd0;
    localparam logic [7:0] CTRL_OFS = 8'd1;

    // Control register bit indices
    localparam int CTRL_RUN_BIT     = 0;
    localparam int CTRL_ONESHOT_BIT = 1;

    // COMMAND nibble bit positions: {FORWARD, BACKWARD, LEFT, RIGHT}
    localparam int CMD_RIGHT_BIT    = 0;
    localparam int CMD_LEFT_BIT     = 1;
    localparam int CMD_BACKWARD_BIT = 2;
    localparam int CMD_FORWARD_BIT  = 3;

    // Datapath widths
    localparam int CMD_W   = 4;
    localparam int PRESC_W = 24;
    localparam int TO_W    = 8;

    // Saturating increment for the packet timeout counter
    function automatic logic [TO_W-1:0] sat_inc8(input logic [TO_W-1:0] v);
        return (v == {TO_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ir_prescaler.sv
// Packet-period prescaler: 24-bit counter that runs 0..PERIOD-1 while
// enabled, wraps, and flags the terminal count. A clear forces it to zero
// and takes priority over counting.
module ir_prescaler
    import ir_pkg::*;
#(
    parameter int unsigned PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PERIOD - 1);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] count_d;

    // Next count: clear wins, otherwise count and wrap at LAST
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = en && (count_q == LAST);

endmodule

// File: rtl/ir_packet_scheduler.sv
// IR packet scheduler: two bus registers (pending command, control) feed an
// IDLE/RUN/FIRE FSM that emits one SEND_PACKET pulse per prescaler period or
// per ONESHOT write. COMMAND is loaded on entry to FIRE so it is valid in the
// same cycle as SEND_PACKET and stays stable for the whole packet.
// Optional feature macro: IR_CMD_TIMEOUT_EN (command timeout / CMD_STALE).
// DBG_STATE exposes the FSM state for observation.
module ir_packet_scheduler
    import ir_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR       = 8'h90,
    parameter int unsigned PACKET_PERIOD   = 10_000_000,
    parameter int unsigned TIMEOUT_PACKETS = 20
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       BUS_ADDR,
    input  logic [7:0]       BUS_DATA_IN,
    input  logic             BUS_WE,
    output logic [CMD_W-1:0] COMMAND,
    output logic             SEND_PACKET,
    output logic             TX_ENABLE,
    output logic             CMD_STALE,
    output logic [1:0]       DBG_STATE
);

    localparam logic [7:0] CMD_ADDR  = BASE_ADDR + CMD_OFS;
    localparam logic [7:0] CTRL_ADDR = BASE_ADDR + CTRL_OFS;

    ir_state_e         state_q, state_d;
    logic              run_q, run_d;
    logic [CMD_W-1:0]  pending_q, pending_d;
    logic [CMD_W-1:0]  command_q, command_d;

    logic cmd_we;
    logic ctrl_we;
    logic oneshot_req;
    logic fire_go;
    logic timed_out;
    logic presc_en;
    logic presc_clr;
    logic presc_tc;

    // Upper data bits only matter for the control register's unused bits
    logic unused_data;
    assign unused_data = ^BUS_DATA_IN[7:4];

    // Bus decode; a ONESHOT arriving while already in FIRE is dropped
    always_comb begin
        cmd_we      = BUS_WE && (BUS_ADDR == CMD_ADDR);
        ctrl_we     = BUS_WE && (BUS_ADDR == CTRL_ADDR);
        oneshot_req = ctrl_we && BUS_DATA_IN[CTRL_ONESHOT_BIT] && (state_q != ST_FIRE);
    end

    // Register-file next values: RUN is stored, ONESHOT never is
    always_comb begin
        run_d     = run_q;
        pending_d = pending_q;
        if (ctrl_we) begin
            run_d = BUS_DATA_IN[CTRL_RUN_BIT];
        end
        if (cmd_we) begin
            pending_d = BUS_DATA_IN[CMD_W-1:0];
        end
    end

    // FSM next state; a terminal count and a ONESHOT landing together both
    // map to a single FIRE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (oneshot_req) begin
                    state_d = ST_FIRE;
                end else if (run_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (oneshot_req) begin
                    state_d = ST_FIRE;
                end else if (!run_q) begin
                    state_d = ST_IDLE;
                end else if (presc_tc) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = run_q ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler control: count through RUN and FIRE so the period between
    // pulses is exactly PACKET_PERIOD; clear whenever stopped or on ONESHOT
    always_comb begin
        fire_go   = (state_d == ST_FIRE);
        presc_en  = run_q && (state_q != ST_IDLE);
        presc_clr = !run_q || oneshot_req;
    end

    // COMMAND loads only on entry to FIRE, from the pending value as it was
    // before any write in that same cycle
    always_comb begin
        command_d = command_q;
        if (fire_go) begin
            command_d = timed_out ? '0 : pending_q;
        end
    end

    // State and register-file flops
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            pending_q <= '0;
            command_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pending_q <= pending_d;
            command_q <= command_d;
        end
    end

`ifdef IR_CMD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            stale_q, stale_d;

    assign timed_out = (to_cnt_q >= TO_W'(TIMEOUT_PACKETS));

    // Timeout counter: count packets since the last command write
    always_comb begin
        to_cnt_d = to_cnt_q;
        stale_d  = stale_q;
        if (cmd_we) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end else if (fire_go) begin
            to_cnt_d = sat_inc8(to_cnt_q);
            if (timed_out) begin
                stale_d = 1'b1;
            end
        end
    end

    // Timeout flops
    always_ff @(posedge CLK) begin
        if (RESET) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stale_q  <= stale_d;
        end
    end

    assign CMD_STALE = stale_q;
`else
    logic [TO_W-1:0] timeout_unused;
    assign timeout_unused = TO_W'(TIMEOUT_PACKETS);
    assign timed_out      = 1'b0;
    assign CMD_STALE      = 1'b0;
`endif

    ir_prescaler #(
        .PERIOD (PACKET_PERIOD)
    ) u_prescaler (
        .clk (CLK),
        .rst (RESET),
        .en  (presc_en),
        .clr (presc_clr),
        .tc  (presc_tc)
    );

    assign COMMAND     = command_q;
    assign SEND_PACKET = (state_q == ST_FIRE);
    assign TX_ENABLE   = run_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Bench for ir_packet_scheduler with PACKET_PERIOD=100, TIMEOUT_PACKETS=3.
// Table of single-cycle bus vectors, then hand-written multi-cycle sequences.
module tb_ir_packet_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA_IN;
    logic       BUS_WE;
    logic [3:0] COMMAND;
    logic       SEND_PACKET;
    logic       TX_ENABLE;
    logic       CMD_STALE;
    logic [1:0] DBG_STATE;

    int checks = 0;
    int errors = 0;

    ir_packet_scheduler #(
        .BASE_ADDR       (8'h90),
        .PACKET_PERIOD   (100),
        .TIMEOUT_PACKETS (3)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_DATA_IN (BUS_DATA_IN),
        .BUS_WE      (BUS_WE),
        .COMMAND     (COMMAND),
        .SEND_PACKET (SEND_PACKET),
        .TX_ENABLE   (TX_ENABLE),
        .CMD_STALE   (CMD_STALE),
        .DBG_STATE   (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_send;
        logic [3:0] exp_cmd;
        logic       exp_txen;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR    = a;
        BUS_DATA_IN = d;
        BUS_WE      = 1'b1;
        tick();
        BUS_WE      = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Advance until SEND_PACKET is seen or the budget runs out
    task automatic wait_pulse(input int max_cycles, output int n);
        n = 0;
        while (SEND_PACKET !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;

        vecs[0]  = '{1'b1, 8'h90, 8'hF5, 1'b0, 4'h0, 1'b0, S_IDLE};
        vecs[1]  = '{1'b1, 8'h92, 8'h03, 1'b0, 4'h0, 1'b0, S_IDLE};
        vecs[2]  = '{1'b0, 8'h91, 8'h02, 1'b0, 4'h0, 1'b0, S_IDLE};
        vecs[3]  = '{1'b1, 8'h91, 8'h02, 1'b1, 4'h5, 1'b0, S_FIRE};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'h5, 1'b0, S_IDLE};
        vecs[5]  = '{1'b1, 8'h90, 8'h0A, 1'b0, 4'h5, 1'b0, S_IDLE};
        vecs[6]  = '{1'b1, 8'h8F, 8'h02, 1'b0, 4'h5, 1'b0, S_IDLE};
        vecs[7]  = '{1'b1, 8'h91, 8'h02, 1'b1, 4'hA, 1'b0, S_FIRE};
        vecs[8]  = '{1'b1, 8'h91, 8'h02, 1'b0, 4'hA, 1'b0, S_IDLE};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b0, 4'hA, 1'b0, S_IDLE};
        vecs[10] = '{1'b1, 8'h91, 8'h01, 1'b0, 4'hA, 1'b1, S_IDLE};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 4'hA, 1'b1, S_RUN};
        vecs[12] = '{1'b1, 8'h91, 8'h00, 1'b0, 4'hA, 1'b0, S_RUN};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b0, 4'hA, 1'b0, S_IDLE};

        // Clock/reset, with a bus write held during reset
        RESET       = 1'b1;
        BUS_WE      = 1'b1;
        BUS_ADDR    = 8'h91;
        BUS_DATA_IN = 8'h03;
        repeat (3) tick();
        BUS_WE = 1'b0;
        check("rst_send",  32'(SEND_PACKET), 32'd0);
        check("rst_cmd",   32'(COMMAND),     32'd0);
        check("rst_txen",  32'(TX_ENABLE),   32'd0);
        check("rst_stale", 32'(CMD_STALE),   32'd0);
        check("rst_state", 32'(DBG_STATE),   32'(S_IDLE));
        RESET = 1'b0;

        // Single-cycle bus vectors
        for (int i = 0; i < 14; i++) begin
            BUS_ADDR    = vecs[i].addr;
            BUS_DATA_IN = vecs[i].data;
            BUS_WE      = vecs[i].we;
            tick();
            BUS_WE = 1'b0;
            check($sformatf("vec%0d_send", i),  32'(SEND_PACKET), 32'(vecs[i].exp_send));
            check($sformatf("vec%0d_cmd", i),   32'(COMMAND),     32'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_txen", i),  32'(TX_ENABLE),   32'(vecs[i].exp_txen));
            check($sformatf("vec%0d_state", i), 32'(DBG_STATE),   32'(vecs[i].exp_state));
        end

        // Periodic packets with CMD=F5
        do_reset();
        bus_write(8'h90, 8'hF5);
        bus_write(8'h91, 8'h01);
        wait_pulse(110, n);
        check("per_first_seen", 32'(SEND_PACKET), 32'd1);
        check("per_first_lat",  32'(n <= 102),    32'd1);
        check("per_first_cmd",  32'(COMMAND),     32'h5);
        check("per_txen",       32'(TX_ENABLE),   32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("per%0d_width", k), 32'(SEND_PACKET), 32'd0);
            wait_pulse(150, n);
            check($sformatf("per%0d_seen", k),     32'(SEND_PACKET), 32'd1);
            check($sformatf("per%0d_interval", k), 32'(n + 1),       32'd100);
            check($sformatf("per%0d_cmd", k),      32'(COMMAND),     32'h5);
        end

        // Command written during FIRE applies at the following packet
        tick();
        bus_write(8'h90, 8'h01);
        wait_pulse(150, n);
        check("fw_seen", 32'(SEND_PACKET), 32'd1);
        check("fw_cmd1", 32'(COMMAND),     32'h1);
        bus_write(8'h90, 8'h03);
        check("fw_hold", 32'(COMMAND),     32'h1);
        check("fw_off",  32'(SEND_PACKET), 32'd0);
        wait_pulse(150, n);
        check("fw_next_seen", 32'(SEND_PACKET), 32'd1);
        check("fw_next_gap",  32'(n),           32'd99);
        check("fw_cmd3",      32'(COMMAND),     32'h3);

        // ONESHOT aligned with terminal count
        repeat (99) tick();
        bus_write(8'h91, 8'h03);
        check("al_send",   32'(SEND_PACKET), 32'd1);
        check("al_cmd",    32'(COMMAND),     32'h3);
        tick();
        check("al_single", 32'(SEND_PACKET), 32'd0);
        wait_pulse(150, n);
        check("al_next_seen", 32'(SEND_PACKET), 32'd1);
        check("al_next_gap",  32'(n),           32'd99);

        // Reset mid-period while running with COMMAND=A
        tick();
        bus_write(8'h90, 8'h0A);
        wait_pulse(150, n);
        check("mr_cmdA", 32'(COMMAND), 32'hA);
        repeat (40) tick();
        RESET       = 1'b1;
        BUS_WE      = 1'b1;
        BUS_ADDR    = 8'h91;
        BUS_DATA_IN = 8'h03;
        tick();
        RESET  = 1'b0;
        BUS_WE = 1'b0;
        check("mr_send",  32'(SEND_PACKET), 32'd0);
        check("mr_cmd",   32'(COMMAND),     32'h0);
        check("mr_txen",  32'(TX_ENABLE),   32'd0);
        check("mr_stale", 32'(CMD_STALE),   32'd0);
        check("mr_state", 32'(DBG_STATE),   32'(S_IDLE));
        pulses = 0;
        repeat (250) begin
            tick();
            if (SEND_PACKET === 1'b1) pulses++;
        end
        check("mr_no_pulse", 32'(pulses), 32'd0);
        bus_write(8'h91, 8'h01);
        wait_pulse(110, n);
        check("mr_rerun_seen", 32'(SEND_PACKET), 32'd1);
        check("mr_rerun_cmd",  32'(COMMAND),     32'h0);

        // Command timeout after three packets
        do_reset();
        bus_write(8'h90, 8'h09);
        bus_write(8'h91, 8'h01);
        for (int p = 1; p <= 4; p++) begin
            wait_pulse(150, n);
            check($sformatf("to_p%0d_seen", p), 32'(SEND_PACKET), 32'd1);
`ifdef IR_CMD_TIMEOUT_EN
            check($sformatf("to_p%0d_cmd", p),   32'(COMMAND),   (p == 4) ? 32'h0 : 32'h9);
            check($sformatf("to_p%0d_stale", p), 32'(CMD_STALE), (p == 4) ? 32'd1 : 32'd0);
`else
            check($sformatf("to_p%0d_cmd", p),   32'(COMMAND),   32'h9);
            check($sformatf("to_p%0d_stale", p), 32'(CMD_STALE), 32'd0);
`endif
            tick();
        end
        bus_write(8'h90, 8'h06);
        check("to_clear_stale", 32'(CMD_STALE), 32'd0);
        wait_pulse(150, n);
        check("to_new_seen",  32'(SEND_PACKET), 32'd1);
        check("to_new_cmd",   32'(COMMAND),     32'h6);
        check("to_new_stale", 32'(CMD_STALE),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_packet_scheduler.md
IR_PACKET_SCHEDULER -- requirements
Module: ir_packet_scheduler

Interface
REQ-001 Parameter BASE_ADDR, default 8'h90, base bus address of the two registers.
REQ-002 Parameter PACKET_PERIOD, default 10_000_000, CLK cycles between periodic packets (10 Hz at 100 MHz); legal range 2_000_000..16_777_215.
REQ-003 Parameter TIMEOUT_PACKETS, default 20, packets without a command write before the command is forced to zero; legal range 1..255.
REQ-004 CLK  input  1  system clock; the block has one clock; reset is synchronous and active-high.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 BUS_ADDR  input  8  processor bus address.
REQ-007 BUS_DATA_IN  input  8  processor bus write data.
REQ-008 BUS_WE  input  1  bus write strobe, one cycle per write.
REQ-009 COMMAND  output  4  command nibble to the IR transmitter: {FORWARD, BACKWARD, LEFT, RIGHT}, bit 0 = RIGHT.
REQ-010 SEND_PACKET  output  1  one-cycle pulse that starts one transmitter packet.
REQ-011 TX_ENABLE  output  1  registered copy of the control-register RUN bit, driven to the transmitter ENABLE input.
REQ-012 CMD_STALE  output  1  high while the command timeout has zeroed the command.

Function
REQ-013 A write with BUS_ADDR==BASE_ADDR SHALL load BUS_DATA_IN[3:0] into the pending-command register; bits [7:4] are ignored.
REQ-014 A write with BUS_ADDR==BASE_ADDR+1 SHALL load RUN from bit 0; bit 1 = ONESHOT is self-clearing and is never stored; other addresses are ignored.
REQ-015 FSM states: IDLE, RUN, FIRE; IDLE->RUN when RUN=1; RUN->IDLE when RUN=0, with the prescaler cleared.
REQ-016 In RUN, a 24-bit prescaler SHALL count 0..PACKET_PERIOD-1 and wrap; at terminal count the FSM enters FIRE.
REQ-017 A write with ONESHOT=1 in IDLE or RUN SHALL enter FIRE on the next cycle and clear the prescaler.
REQ-018 FIRE lasts exactly one cycle: SEND_PACKET=1, and COMMAND loads the pending command (or 4'b0000 when stale); FIRE then returns to RUN if RUN=1, else to IDLE.
REQ-019 COMMAND SHALL change only in the FIRE cycle and is never updated mid-packet.
REQ-020 A terminal count coinciding with a ONESHOT write SHALL produce exactly one SEND_PACKET pulse.
REQ-021 A command write in the same cycle as FIRE SHALL take effect at the next FIRE, not the current one.
REQ-022 SEND_PACKET latency: ONESHOT write in cycle N -> SEND_PACKET high in cycle N+1 and N+1 only.
REQ-023 A ONESHOT write during FIRE SHALL be ignored.

Reset
REQ-024 On RESET: FSM=IDLE, prescaler=0, pending command=0, COMMAND=4'b0000, SEND_PACKET=0, TX_ENABLE=0, CMD_STALE=0, timeout counter=0.
REQ-025 RESET has priority over any simultaneous bus write or FIRE.

Configuration
REQ-026 Macro IR_CMD_TIMEOUT_EN defined: an 8-bit counter SHALL increment on each FIRE and clear on every command write; on reaching TIMEOUT_PACKETS, CMD_STALE=1 and FIRE loads 4'b0000; the next command write clears CMD_STALE.
REQ-027 Macro IR_CMD_TIMEOUT_EN undefined: no counter, CMD_STALE tied to 0, and FIRE always loads the pending command.

Structure
REQ-028 Shared package ir_pkg SHALL hold the FSM state enum, register offsets (CMD_OFS=0, CTRL_OFS=1), control bit indices and the COMMAND bit-position constants.
REQ-029 Sub-module ir_prescaler (counter, clear input, terminal-count pulse output) SHALL be instantiated once; all other logic stays in the top.

Verification (bench uses PACKET_PERIOD=100, TIMEOUT_PACKETS=3)
REQ-030 Write CMD=8'hF5, then CTRL=8'h01 -> SEND_PACKET every 100 cycles, COMMAND=4'h5 from the first pulse, TX_ENABLE=1.
REQ-031 ONESHOT write (CTRL=8'h02) in IDLE at cycle N -> single SEND_PACKET at N+1, FSM back in IDLE, no further pulses.
REQ-032 CMD=4'h3 written in the FIRE cycle while COMMAND=4'h1 -> COMMAND stays 4'h1 for that packet and becomes 4'h3 at the next pulse.
REQ-033 ONESHOT write aligned with terminal count -> exactly one pulse, next pulse 100 cycles later.
REQ-034 IR_CMD_TIMEOUT_EN defined, RUN with CMD=4'h9 and no further writes -> pulses 1-3 carry 4'h9, pulse 4 carries 4'h0 with CMD_STALE=1; a CMD write clears CMD_STALE.
REQ-035 RESET asserted mid-period in RUN with COMMAND=4'hA -> next cycle all outputs match REQ-024, and no pulse occurs until RUN is rewritten.
